// File: rtl/conv_scheduler.sv
// conv_scheduler: walks oy/ox/ky/kx over a convolution job, emitting tap addresses
// and counting window results until every output window has been reported.
module conv_scheduler #(
  parameter int ADDR_WIDTH = 13,
  parameter int MAX_MACS   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] img_row,
  input  logic [ADDR_WIDTH-1:0] img_col,
  input  logic [ADDR_WIDTH-1:0] ker_row,
  input  logic [ADDR_WIDTH-1:0] ker_col,
  input  logic [ADDR_WIDTH-1:0] img_base,
  input  logic [ADDR_WIDTH-1:0] ker_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  input  logic                  tap_ready,
  input  logic                  res_valid,
  output logic                  tap_valid,
  output logic [ADDR_WIDTH-1:0] img_addr,
  output logic [ADDR_WIDTH-1:0] ker_addr,
  output logic                  last_tap,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [2*AW-1:0] MACS = (2*AW)'(MAX_MACS);
  typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;
  state_t r_state;
  logic [AW-1:0] r_img_row, r_img_col, r_ker_row, r_ker_col, r_img_base, r_ker_base, r_out_base;
  logic [AW-1:0] r_oy, r_ox, r_ky, r_kx, r_res_cnt;
  logic [AW-1:0] w_out_row, w_out_col, w_total, w_oy, w_ox, w_ky, w_kx;
  logic [2*AW-1:0] w_macs;
  logic w_bad, w_kx_end, w_ky_end, w_ox_end, w_oy_end, w_win_end, w_first, w_accept, w_load, w_count;
  // w_* indices are the tap to present next: all-zero from CHECK, else the successor of r_*
  always_comb begin
    w_out_row = r_img_row - r_ker_row + ONE;
    w_out_col = r_img_col - r_ker_col + ONE;
    w_total   = w_out_row * w_out_col;
    w_macs    = {{AW{1'b0}}, r_ker_row} * {{AW{1'b0}}, r_ker_col};
    w_bad     = r_ker_row == '0 || r_ker_col == '0 || r_ker_row > r_img_row ||
                r_ker_col > r_img_col || w_macs > MACS;
    w_kx_end  = r_kx == r_ker_col - ONE;
    w_ky_end  = r_ky == r_ker_row - ONE;
    w_ox_end  = r_ox == w_out_col - ONE;
    w_oy_end  = r_oy == w_out_row - ONE;
    w_win_end = w_kx_end && w_ky_end;
    w_first   = r_state == CHECK;
    w_kx      = (w_first || w_kx_end) ? '0 : r_kx + ONE;
    w_ky      = (w_first || w_win_end) ? '0 : w_kx_end ? r_ky + ONE : r_ky;
    w_ox      = (w_first || (w_win_end && w_ox_end)) ? '0 : w_win_end ? r_ox + ONE : r_ox;
    w_oy      = w_first ? '0 : (w_win_end && w_ox_end) ? r_oy + ONE : r_oy;
    w_accept  = tap_valid && tap_ready;
    w_load    = (w_first && !w_bad) ||
                (r_state == RUN && w_accept && !(w_win_end && w_ox_end && w_oy_end));
    w_count   = res_valid && (r_state == RUN || r_state == DRAIN) && r_res_cnt != '1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_img_row  <= '0;
      r_img_col  <= '0;
      r_ker_row  <= '0;
      r_ker_col  <= '0;
      r_img_base <= '0;
      r_ker_base <= '0;
      r_out_base <= '0;
      r_oy       <= '0;
      r_ox       <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_res_cnt  <= '0;
      tap_valid  <= 1'b0;
      img_addr   <= '0;
      ker_addr   <= '0;
      last_tap   <= 1'b0;
      out_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_count) r_res_cnt <= r_res_cnt + ONE;
      if (w_load) begin
        r_oy     <= w_oy;
        r_ox     <= w_ox;
        r_ky     <= w_ky;
        r_kx     <= w_kx;
        img_addr <= r_img_base + (w_oy + w_ky) * r_img_col + w_ox + w_kx;
        ker_addr <= r_ker_base + w_ky * r_ker_col + w_kx;
        last_tap <= w_ky == r_ker_row - ONE && w_kx == r_ker_col - ONE;
        out_addr <= r_out_base + w_oy * w_out_col + w_ox;
      end
      case (r_state)
        IDLE: if (start) begin
          r_img_row  <= img_row;
          r_img_col  <= img_col;
          r_ker_row  <= ker_row;
          r_ker_col  <= ker_col;
          r_img_base <= img_base;
          r_ker_base <= ker_base;
          r_out_base <= out_base;
          r_res_cnt  <= '0;
          cfg_err    <= 1'b0;
          busy       <= 1'b1;
          r_state    <= CHECK;
        end
        CHECK: begin
          r_state   <= w_bad ? DONE : RUN;
          cfg_err   <= w_bad;
          done      <= w_bad;
          tap_valid <= !w_bad;
        end
        RUN: if (w_accept && !w_load) begin
          tap_valid <= 1'b0;
          last_tap  <= 1'b0;
          r_state   <= DRAIN;
        end
        DRAIN: if (r_res_cnt >= w_total) begin
          done    <= 1'b1;
          r_state <= DONE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
